id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with skid entry, writeback forwarding and stall counter
//
// Purpose:
//   Holds decoded instructions between the decode and ALU stages. A main
//   entry (M) drives the ALU stage directly. A skid entry (S) absorbs one
//   extra instruction so that in_ready is a pure register and has no
//   combinational path from out_ready.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            decode-side handshake
//   in_a, in_b, in_alu_op          decoded operands and ALU operation
//   in_rs1, in_rs2, in_rd          source / destination register indices
//   in_reg_write                   writeback enable
//   flush                          discard all held instructions
//   fwd_en, fwd_rd, fwd_data       writeback forwarding port
//   out_valid / out_ready          ALU-side handshake
//   out_a, out_b, out_alu_op       ALU operands and operation
//   out_rd, out_reg_write          writeback tag
//   stall_cnt                      saturating count of back-pressure cycles
module id_ex_reg #(
    parameter int DATA_LEN  = 32,
    parameter int RADDR_LEN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_LEN-1:0]  in_a,
    input  logic [DATA_LEN-1:0]  in_b,
    input  logic [3:0]           in_alu_op,
    input  logic [RADDR_LEN-1:0] in_rs1,
    input  logic [RADDR_LEN-1:0] in_rs2,
    input  logic [RADDR_LEN-1:0] in_rd,
    input  logic                 in_reg_write,
    input  logic                 flush,
    input  logic                 fwd_en,
    input  logic [RADDR_LEN-1:0] fwd_rd,
    input  logic [DATA_LEN-1:0]  fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_LEN-1:0]  out_a,
    output logic [DATA_LEN-1:0]  out_b,
    output logic [3:0]           out_alu_op,
    output logic [RADDR_LEN-1:0] out_rd,
    output logic                 out_reg_write,
    output logic [15:0]          stall_cnt
);

    typedef struct packed {
        logic [DATA_LEN-1:0]  a;
        logic [DATA_LEN-1:0]  b;
        logic [3:0]           alu_op;
        logic [RADDR_LEN-1:0] rs1;
        logic [RADDR_LEN-1:0] rs2;
        logic [RADDR_LEN-1:0] rd;
        logic                 reg_write;
    } entry_t;

    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   m_valid_q, m_valid_d;
    logic   s_valid_q, s_valid_d;
    logic [15:0] stall_q, stall_d;

    entry_t in_entry;
    logic   accept;
    logic   issue;

    // Replace operands whose source index matches the writeback port.
    // Index 0 is the hard-wired zero register and never forwards.
    function automatic entry_t fwd_entry(
        input entry_t                 e,
        input logic                   en,
        input logic [RADDR_LEN-1:0]   rd,
        input logic [DATA_LEN-1:0]    data
    );
        entry_t r;
        r = e;
        if (en && (rd != '0)) begin
            if (rd == e.rs1) r.a = data;
            if (rd == e.rs2) r.b = data;
        end
        return r;
    endfunction

    assign in_entry = '{a: in_a, b: in_b, alu_op: in_alu_op, rs1: in_rs1,
                        rs2: in_rs2, rd: in_rd, reg_write: in_reg_write};

    // in_ready depends only on the skid register.
    assign in_ready = ~s_valid_q;
    assign accept   = in_valid & in_ready;
    assign issue    = m_valid_q & out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        // Entries that stay put keep tracking the writeback port.
        if (m_valid_q) m_d = fwd_entry(m_q, fwd_en, fwd_rd, fwd_data);
        if (s_valid_q) s_d = fwd_entry(s_q, fwd_en, fwd_rd, fwd_data);

        if (s_valid_q) begin
            // in_ready is low, so no accept can coincide with this.
            if (issue) begin
                m_d       = fwd_entry(s_q, fwd_en, fwd_rd, fwd_data);
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q || issue) begin
                m_d       = fwd_entry(in_entry, fwd_en, fwd_rd, fwd_data);
                m_valid_d = 1'b1;
            end else begin
                s_d       = fwd_entry(in_entry, fwd_en, fwd_rd, fwd_data);
                s_valid_d = 1'b1;
            end
        end else if (issue) begin
            // M drains; its data fields are left as they were.
            m_d       = m_q;
            m_valid_d = 1'b0;
        end

        // Flush wins over everything; the fields simply hold.
        if (flush) begin
            m_d       = m_q;
            s_d       = s_q;
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end

        stall_d = stall_q;
        if (m_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            stall_q   <= stall_d;
        end
    end

    assign out_valid     = m_valid_q;
    assign out_a         = m_q.a;
    assign out_b         = m_q.b;
    assign out_alu_op    = m_q.alu_op;
    assign out_rd        = m_q.rd;
    assign out_reg_write = m_q.reg_write;
    assign stall_cnt     = stall_q;

endmodule
